apb_master_bridge: RTL and testbench

//  Converts a valid/ready command stream into APB5 transfers; returns one response per command.

---
 rtl/apb_master_bridge.sv | 174 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB5 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one registered response (read data, error, wait-state count) per command.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [WAIT_WIDTH-1:0]   rsp_waits,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [WAIT_WIDTH-1:0]   rsp_waits_q, rsp_waits_d;
  logic [WAIT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    accept;
  logic                    complete;

  // Gated by PRESETn so cmd_ready also reads 0 while reset is asserted.
  assign cmd_ready = PRESETn && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state_q == ACCESS) && psel_q && penable_q && PREADY;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_waits_d = rsp_waits_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = rsp_valid_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pprot_d   = cmd_prot;
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_strb;
          end else begin
            pstrb_d  = '0;
          end
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (complete) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_waits_d = wait_cnt_q;
        end else if (!PREADY && (wait_cnt_q != {WAIT_WIDTH{1'b1}})) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_waits_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_waits_q <= rsp_waits_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PPROT     = pprot_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_waits = rsp_waits_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: table of transfers plus hand-written
// sequences for response backpressure and mid-transfer reset.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  rsp_waits;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [15:0] waits;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] expRdata;
    logic        expErr;
    logic [7:0]  expWaits;
    logic [3:0]  expPstrb;
    logic [31:0] expPwdata;
  } vec_t;

  vec_t vecs [6];
  vec_t v;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_WIDTH(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_waits(rsp_waits),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveCmd(input vec_t c);
    cmd_valid = 1'b1;
    cmd_addr  = c.addr;
    cmd_write = c.write;
    cmd_wdata = c.wdata;
    cmd_strb  = c.strb;
    cmd_prot  = c.prot;
  endtask

  // Called in the first cycle after acceptance: bus must be in SETUP with the new payload.
  task automatic checkSetup(input vec_t c);
    checkOutput("setup_psel", {63'd0, PSEL}, 64'd1);
    checkOutput("setup_penable", {63'd0, PENABLE}, 64'd0);
    checkOutput("setup_paddr", {32'd0, PADDR}, {32'd0, c.addr});
    checkOutput("setup_pwrite", {63'd0, PWRITE}, {63'd0, c.write});
    checkOutput("setup_pprot", {61'd0, PPROT}, {61'd0, c.prot});
    checkOutput("setup_pstrb", {60'd0, PSTRB}, {60'd0, c.expPstrb});
    checkOutput("setup_pwdata", {32'd0, PWDATA}, {32'd0, c.expPwdata});
    checkOutput("setup_rsp_valid", {63'd0, rsp_valid}, 64'd0);
  endtask

  // Runs ACCESS with c.waits stalled cycles (garbage PRDATA/PSLVERR=1 while stalled), then completes.
  task automatic finishXfer(input vec_t c);
    logic stable;
    stable    = 1'b1;
    PREADY    = 1'b0;
    PSLVERR   = 1'b1;
    PRDATA    = 32'hFFFF_FFFF;
    @(negedge PCLK);
    checkOutput("access_penable", {62'd0, PSEL, PENABLE}, 64'd3);
    for (int i = 0; i < int'(c.waits); i++) begin
      @(negedge PCLK);
      if (!(PSEL && PENABLE) || PADDR !== c.addr || PSTRB !== c.expPstrb ||
          PWDATA !== c.expPwdata || PWRITE !== c.write || PPROT !== c.prot || rsp_valid)
        stable = 1'b0;
    end
    checkOutput("access_stable", {63'd0, stable}, 64'd1);
    PREADY  = 1'b1;
    PSLVERR = c.err;
    PRDATA  = c.prdata;
    @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    checkOutput("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("rsp_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
    checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, c.expRdata});
    checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, c.expErr});
    checkOutput("rsp_waits", {56'd0, rsp_waits}, {56'd0, c.expWaits});
    checkOutput("idle_paddr_hold", {32'd0, PADDR}, {32'd0, c.addr});
  endtask

  task automatic applyStimulus(input vec_t c);
    int n;
    n = 0;
    driveCmd(c);
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput("accept_timeout", {63'd0, (n < 20)}, 64'd1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    checkSetup(c);
    finishXfer(c);
  endtask

  initial begin
    logic allQuiet;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    // write, addr, wdata, strb, prot, waits, prdata, err | rdata, err, waits, pstrb, pwdata
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 16'd0, 32'h0, 1'b0,
                32'h0, 1'b0, 8'd0, 4'hF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'hAAAA_AAAA, 4'h5, 3'd1, 16'd3, 32'h1234_5678, 1'b0,
                32'h1234_5678, 1'b0, 8'd3, 4'h0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 3'd2, 16'd2, 32'h5555_5555, 1'b1,
                32'h0, 1'b1, 8'd2, 4'h3, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 3'd7, 16'd1, 32'hA5A5_A5A5, 1'b1,
                32'hA5A5_A5A5, 1'b1, 8'd1, 4'h0, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'h8, 3'd5, 16'd0, 32'hFFFF_0000, 1'b0,
                32'h0, 1'b0, 8'd0, 4'h8, 32'h0000_0001};
    vecs[5] = '{1'b0, 32'h0000_0044, 32'h0, 4'hF, 3'd0, 16'd300, 32'h0BAD_C0DE, 1'b0,
                32'h0BAD_C0DE, 1'b0, 8'd255, 4'h0, 32'h0000_0001};

    #3;
    checkOutput("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    checkOutput("reset_bus", {PADDR, 1'b0, PPROT, PSEL, PENABLE, PWRITE, PSTRB, 17'd0}, 64'd0);
    checkOutput("reset_pwdata", {32'd0, PWDATA}, 64'd0);
    checkOutput("reset_rsp", {rsp_rdata, 22'd0, rsp_valid, rsp_err, rsp_waits}, 64'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Response backpressure: the held response blocks new commands.
    rsp_ready = 1'b0;
    v = '{1'b1, 32'h0000_0050, 32'h1122_3344, 4'hF, 3'd3, 16'd0, 32'h0, 1'b0,
          32'h0, 1'b0, 8'd0, 4'hF, 32'h1122_3344};
    driveCmd(v);
    @(negedge PCLK);
    allQuiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready || PSEL || !rsp_valid) allQuiet = 1'b0;
      @(negedge PCLK);
    end
    checkOutput("backpressure_blocked", {63'd0, allQuiet}, 64'd1);
    rsp_ready = 1'b1;
    #1;
    checkOutput("backpressure_release_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    checkSetup(v);
    finishXfer(v);

    // Reset while in ACCESS after two stalled cycles: no response may appear.
    v = '{1'b0, 32'h0000_0070, 32'h0, 4'hF, 3'd0, 16'd0, 32'h0, 1'b0,
          32'h0, 1'b0, 8'd0, 4'h0, 32'h1122_3344};
    driveCmd(v);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    checkSetup(v);
    PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("pre_reset_access", {62'd0, PSEL, PENABLE}, 64'd3);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("midreset_outputs", {60'd0, PSEL, PENABLE, rsp_valid, cmd_ready}, 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("post_reset_no_rsp", {62'd0, rsp_valid, PSEL}, 64'd0);

    v = '{1'b1, 32'h0000_0060, 32'h9988_7766, 4'h6, 3'd4, 16'd1, 32'h0, 1'b0,
          32'h0, 1'b0, 8'd1, 4'h6, 32'h9988_7766};
    applyStimulus(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
